// File: rtl/fb_line_scheduler.sv
// Frame-buffer line scheduler: arbitrates one frame memory between line
// fetches (triggered by vs/hs) into a double-banked line buffer and
// single-cycle writer requests. Fetches always take priority over writes.
module fb_line_scheduler #(
  parameter int LINE_W = 480,
  parameter int LINES  = 272,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs,
  input  logic              hs,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [8:0]        lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              busy,
  output logic              underrun
);

  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(LINE_W);
  localparam logic [8:0]        X_LAST    = 9'(LINE_W - 1);
  localparam logic [LW-1:0]     LINE_LAST = LW'(LINES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, WRITE = 2'd3} state_t;

  state_t            state, state_nxt;
  logic              vs_q, vs_q2, hs_q, hs_q2;
  logic              armed, pend;
  logic              vs_trig, hs_trig, trig, fetch_req, start_fetch, start_write, last_x;
  logic [LW-1:0]     line_idx;
  logic [ADDR_W-1:0] base, new_base, addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [8:0]        x;

  // vs beats a simultaneous hs; hs only counts once armed by a vs and
  // while lines remain in the frame.
  assign vs_trig     = vs_q & ~vs_q2;
  assign hs_trig     = hs_q & ~hs_q2 & armed & (line_idx != LINE_LAST) & ~vs_trig;
  assign trig        = vs_trig | hs_trig;
  assign fetch_req   = trig | pend;
  assign new_base    = vs_trig ? '0 : base + STEP;
  assign last_x      = (x == X_LAST);
  assign start_fetch = ((state == IDLE) && fetch_req) ||
                       (((state == FETCH) || (state == DRAIN)) && trig);
  assign start_write = (state == IDLE) && !fetch_req && wr_req;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign lb_wdata  = lb_we ? mem_rdata : '0;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic; a trigger during a fetch restarts it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_req) state_nxt = FETCH;
               else if (wr_req) state_nxt = WRITE;
      FETCH:   if (trig) state_nxt = FETCH;
               else if (last_x) state_nxt = DRAIN;
      DRAIN:   state_nxt = trig ? FETCH : IDLE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    wr_ack   = 1'b0;
    busy     = 1'b0;
    underrun = 1'b0;
    case (state)
      FETCH: begin
        mem_en   = 1'b1;
        busy     = 1'b1;
        underrun = trig;
      end
      DRAIN: begin
        busy     = 1'b1;
        underrun = trig;
      end
      WRITE: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        wr_ack = 1'b1;
      end
      default: ;
    endcase
  end

  // Sync edge registers, line/base tracking, address generation and the
  // one-cycle read-to-line-buffer pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q     <= 1'b0;
      vs_q2    <= 1'b0;
      hs_q     <= 1'b0;
      hs_q2    <= 1'b0;
      armed    <= 1'b0;
      pend     <= 1'b0;
      line_idx <= '0;
      base     <= '0;
      x        <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lb_we    <= 1'b0;
      lb_addr  <= '0;
      lb_bank  <= 1'b0;
    end else begin
      vs_q  <= vs;
      vs_q2 <= vs_q;
      hs_q  <= hs;
      hs_q2 <= hs_q;
      if (vs_trig) begin
        line_idx <= '0;
        base     <= '0;
        armed    <= 1'b1;
      end else if (hs_trig) begin
        line_idx <= line_idx + LW'(1);
        base     <= new_base;
      end
      // A trigger landing in WRITE is held until the FSM is back in IDLE.
      if ((state == WRITE) && trig) pend <= 1'b1;
      else if (state == IDLE)       pend <= 1'b0;
      if (start_fetch)          x <= '0;
      else if (state == FETCH)  x <= x + 9'd1;
      if (start_fetch) begin
        addr_q <= trig ? new_base : base;
      end else if ((state == FETCH) && !last_x) begin
        addr_q <= addr_q + ADDR_W'(1);
      end else if (start_write) begin
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
      end
      lb_we   <= (state == FETCH);
      lb_addr <= x;
      lb_bank <= line_idx[0];
    end
  end

endmodule

// File: doc/fb_line_scheduler.md
FB_LINE_SCHEDULER -- requirements
Module: fb_line_scheduler

Interface
REQ-001 Parameter LINE_W, default 480: pixels fetched per line; matches the real-display width.
REQ-002 Parameter LINES, default 272: lines per frame to fetch.
REQ-003 Parameter ADDR_W, default 17: frame-memory address width; must satisfy LINE_W*LINES <= 2^ADDR_W.
REQ-004 Parameter DATA_W, default 16: pixel width.
REQ-005 clk  in  1  pixel clock; the only clock.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 vs  in  1  vertical sync from the timing generator; active-high.
REQ-008 hs  in  1  horizontal sync from the timing generator; active-high.
REQ-009 wr_req  in  1  writer request; held high until acknowledged.
REQ-010 wr_addr  in  ADDR_W  writer address.
REQ-011 wr_data  in  DATA_W  writer data.
REQ-012 wr_ack  out  1  one-cycle pulse: write issued to memory this cycle.
REQ-013 mem_en  out  1  memory access strobe.
REQ-014 mem_we  out  1  1 = write, 0 = read; valid while mem_en=1.
REQ-015 mem_addr  out  ADDR_W  memory address.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 mem_rdata  in  DATA_W  read data; valid exactly 1 cycle after a read strobe.
REQ-018 lb_we  out  1  line-buffer write enable.
REQ-019 lb_bank  out  1  line-buffer bank select; equals bit 0 of the fetched line index.
REQ-020 lb_addr  out  9  line-buffer pixel index, 0..LINE_W-1.
REQ-021 lb_wdata  out  DATA_W  line-buffer data; equal to mem_rdata.
REQ-022 busy  out  1  high while a line fetch is in progress.
REQ-023 underrun  out  1  one-cycle pulse: a fetch was aborted by a new trigger.

Function
REQ-024 vs and hs SHALL be registered once, with rising edges detected on the registered copies; trigger latency from input edge to first mem_en is 2 cycles.
REQ-025 A vs rising edge SHALL set line index to 0, set base address to 0, and trigger a fetch of line 0.
REQ-026 An hs rising edge SHALL trigger a fetch of line index+1 and add LINE_W to the base address (adder only, no multiplier).
REQ-027 After line LINES-1 has been triggered, further hs edges SHALL be ignored until the next vs edge.
REQ-028 If vs and hs rise in the same cycle, vs SHALL win.
REQ-029 The FSM SHALL have states IDLE, FETCH, DRAIN and WRITE.
REQ-030 IDLE -> FETCH on a trigger; otherwise IDLE -> WRITE on wr_req.
REQ-031 If a trigger and wr_req occur in the same IDLE cycle, the fetch SHALL win and the write SHALL wait.
REQ-032 FETCH SHALL issue LINE_W consecutive reads, one per cycle: mem_en=1, mem_we=0, mem_addr = base + x for x = 0..LINE_W-1.
REQ-033 After the last read, FETCH -> DRAIN for 1 cycle, then DRAIN -> IDLE.
REQ-034 Each read SHALL produce lb_we=1 one cycle later, with lb_addr = x delayed by 1 cycle and lb_wdata = mem_rdata.
REQ-035 busy SHALL be 1 in FETCH and DRAIN.
REQ-036 WRITE SHALL last 1 cycle with mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data and wr_ack=1, then return to IDLE.
REQ-037 Back-to-back writes therefore SHALL take 2 cycles each.
REQ-038 A trigger arriving in FETCH or DRAIN SHALL pulse underrun, abort the current line, and restart FETCH at x=0 for the new line on the next cycle.
REQ-039 On abort, the pending last lb_we of the aborted line SHALL still complete.
REQ-040 Outside FETCH and WRITE, mem_en SHALL be 0; when idle, mem_addr and mem_wdata SHALL hold their last values.
REQ-041 lb_we SHALL never be asserted while the FSM is in WRITE, excluding the trailing pipeline slot.

Reset
REQ-042 On rst=1, SHALL asynchronously enter IDLE with line index=0, base=0, sync registers=0, and all outputs 0.
REQ-043 After rst deasserts, the first trigger SHALL be a vs rising edge; hs edges SHALL be ignored until then.
REQ-044 rst asserted mid-fetch or mid-write SHALL abandon the operation; no wr_ack is issued for an interrupted request.

Verification
REQ-045 vs pulse, LINE_W=480: mem_en high 480 cycles starting 2 cycles after the edge with addresses 0..479, lb_we high 480 cycles, lb_bank=0, busy high 481 cycles.
REQ-046 Three hs edges after vs: lines 1..3 fetched at bases 480, 960, 1440; lb_bank toggles 1, 0, 1.
REQ-047 wr_req held during a fetch: no wr_ack until DRAIN completes, then one wr_ack with mem_we=1 and mem_addr=wr_addr.
REQ-048 hs edge 100 cycles into a fetch: one underrun pulse, and the new line restarts at x=0 with base incremented by LINE_W.
REQ-049 272 hs edges after vs: the 272nd and later edges produce no mem_en until the next vs, and a same-cycle vs+hs starts at line 0.
REQ-050 rst asserted during FETCH: all outputs 0 in the same cycle; with hs pulses only after release, no fetch occurs.
